// File: rtl/am_sweep_ctrl.sv
// am_sweep_ctrl: steps the AM wave generator through a programmed range with settle blanking and fixed dwell.
module am_sweep_ctrl #(
  parameter int DWELL_LEN  = 1000,
  parameter int SETTLE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] step_start,
  input  logic [7:0] step_stop,
  input  logic [7:0] step_inc,
  input  logic [7:0] mode_sw,
  output logic [7:0] step,
  output logic [7:0] switches,
  output logic       sample_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] step_idx
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DWELL, DONE} state_t;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] DWELL_LAST  = 16'(DWELL_LEN - 1);
  state_t      state;
  logic [7:0]  start_q, stop_q, inc_q, mode_q, settle_cnt;
  logic [15:0] dwell_cnt;
  logic [8:0]  nxt;
  logic        sweep_end;
  assign nxt       = {1'b0, step} + {1'b0, inc_q};
  // overflow, passing the stop value, or a zero increment all end the sweep
  assign sweep_end = nxt[8] | (nxt[7:0] > stop_q) | (inc_q == 8'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= '0;
      stop_q       <= '0;
      inc_q        <= '0;
      mode_q       <= '0;
      settle_cnt   <= '0;
      dwell_cnt    <= '0;
      step         <= '0;
      switches     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_idx     <= '0;
    end else if (abort) begin
      state        <= IDLE;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            start_q <= step_start;
            stop_q  <= step_stop;
            inc_q   <= step_inc;
            mode_q  <= mode_sw;
            state   <= LOAD;
          end
        end
        LOAD: begin
          step       <= start_q;
          switches   <= mode_q;
          step_idx   <= '0;
          settle_cnt <= '0;
          busy       <= 1'b1;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            dwell_cnt    <= '0;
            sample_valid <= 1'b1;
            state        <= DWELL;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        DWELL: begin
          if (dwell_cnt == DWELL_LAST) begin
            step_idx     <= step_idx + {7'd0, step_idx != 8'hff};
            sample_valid <= 1'b0;
            if (sweep_end) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              step       <= nxt[7:0];
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_am_sweep_ctrl.sv
// tb_am_sweep_ctrl: directed sweeps with a per-cycle expected-output queue for am_sweep_ctrl.
module tb_am_sweep_ctrl;
  localparam int DL = 4;
  localparam int SC = 3;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] step_start = '0, step_stop = '0, step_inc = '0, mode_sw = '0;
  logic [7:0] step, switches, step_idx;
  logic       sample_valid, busy, done;
  typedef struct packed {logic [7:0] st; logic sv; logic bz; logic dn;} ent_t;
  ent_t q[$];
  int   tests = 0, fails = 0, exp_idx = 0;
  logic [7:0] exp_step = '0;

  am_sweep_ctrl #(.DWELL_LEN(DL), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .step_start(step_start), .step_stop(step_stop), .step_inc(step_inc), .mode_sw(mode_sw),
    .step(step), .switches(switches), .sample_valid(sample_valid), .busy(busy),
    .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic sv, input logic bz, input logic dn);
    ent_t e;
    e = {8'(s), sv, bz, dn};
    q.push_back(e);
  endtask

  // expected trace from the start-accept edge onward, one entry per cycle
  task automatic build(input int a, input int b, input int c);
    int s, n;
    s = a;
    exp_idx = 0;
    push(exp_step, 0, 0, 0);
    while (1) begin
      repeat (SC) push(s, 0, 1, 0);
      repeat (DL) push(s, 1, 1, 0);
      exp_idx++;
      n = s + c;
      if (n > 255 || n > b || c == 0) break;
      s = n;
    end
    push(s, 0, 0, 1);
    push(s, 0, 0, 0);
    exp_step = 8'(s);
  endtask

  task automatic cmp_head();
    ent_t e;
    e = q[0];
    chk("step", 32'(step), 32'(e.st));
    chk("sample_valid", 32'(sample_valid), 32'(e.sv));
    chk("busy", 32'(busy), 32'(e.bz));
    chk("done", 32'(done), 32'(e.dn));
  endtask

  task automatic kick(input int a, input int b, input int c, input int m);
    @(negedge clk);
    step_start = 8'(a); step_stop = 8'(b); step_inc = 8'(c); mode_sw = 8'(m);
    start = 1'b1;
    build(a, b, c);
    @(negedge clk);
    start = 1'b0;
    step_start = 8'd99; step_stop = 8'd255; step_inc = 8'd1; mode_sw = 8'h00;
  endtask

  task automatic check(input int n, input bit noise);
    repeat (n) begin
      cmp_head();
      start = noise && q[0].bz && ($urandom_range(0, 1) == 1);
      void'(q.pop_front());
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_step", 32'(step), 0);
    chk("rst_switches", 32'(switches), 0);
    chk("rst_flags", {29'd0, sample_valid, busy, done}, 0);
    chk("rst_idx", 32'(step_idx), 0);
    rst = 1'b0;
    // T1: 10,20,30 inclusive end
    kick(10, 30, 10, 8'hA5);
    check(q.size(), 0);
    chk("t1_idx", 32'(step_idx), 3);
    chk("t1_switches", 32'(switches), 32'h A5);
    // T2: overflow ends sweep
    kick(250, 255, 10, 8'h3C);
    check(q.size(), 0);
    chk("t2_idx", 32'(step_idx), 1);
    chk("t2_step", 32'(step), 250);
    // T3: zero increment
    kick(5, 100, 0, 8'h11);
    check(q.size(), 0);
    chk("t3_idx", 32'(step_idx), 1);
    // T4: abort in second dwell cycle of step 20, with a simultaneous start
    kick(10, 30, 10, 8'h22);
    check(12, 0);
    cmp_head();
    abort = 1'b1; start = 1'b1; step_start = 8'd77;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    q.delete();
    exp_step = 8'd20;
    repeat (3) begin
      chk("t4_busy", 32'(busy), 0);
      chk("t4_valid", 32'(sample_valid), 0);
      chk("t4_done", 32'(done), 0);
      chk("t4_step", 32'(step), 20);
      @(negedge clk);
    end
    chk("t4_idx", 32'(step_idx), 1);
    // T6: start above stop gives a single dwell
    kick(40, 20, 5, 8'h5A);
    check(q.size(), 0);
    chk("t6_idx", 32'(step_idx), 1);
    chk("t6_switches", 32'(switches), 32'h5A);
    // T5: start pulses while busy are ignored, then reset mid-SETTLE
    kick(10, 30, 10, 8'h77);
    check(q.size(), 1);
    chk("t5_idx", 32'(step_idx), 3);
    kick(60, 90, 15, 8'h66);
    check(2, 0);
    cmp_head();
    rst = 1'b1;
    #1;
    chk("t5_rst_step", 32'(step), 0);
    chk("t5_rst_switches", 32'(switches), 0);
    chk("t5_rst_flags", {29'd0, sample_valid, busy, done}, 0);
    chk("t5_rst_idx", 32'(step_idx), 0);
    q.delete();
    exp_step = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    kick(0, 20, 10, 8'h01);
    check(q.size(), 0);
    chk("t5_after_idx", 32'(step_idx), 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
